// File: rtl/main_memory_responder.sv
// Word-addressed backing store answering one request at a time after a
// fixed access latency, with out-of-range detection.
module main_memory_responder #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int MEM_DEPTH_LOG2 = 8,
   parameter int LATENCY        = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  busy
);

   localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
   localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                    state_q;
   logic [CW-1:0]             cnt_q;
   logic                      wr_q;
   logic                      oor_q;
   logic [MEM_DEPTH_LOG2-1:0] idx_q;
   logic                      req_ready_q;
   logic                      resp_valid_q;
   logic [DATA_WIDTH-1:0]     resp_rdata_q;
   logic                      resp_err_q;
   logic                      busy_q;
   logic [DATA_WIDTH-1:0]     mem_q [DEPTH];

   logic                      accept;
   logic                      req_oor;
   logic [MEM_DEPTH_LOG2-1:0] req_idx;

   assign accept  = req_valid && req_ready_q;
   assign req_idx = req_addr[MEM_DEPTH_LOG2-1:0];

   // A full-width storage map has no out-of-range addresses.
   if (MEM_DEPTH_LOG2 < ADDR_WIDTH) begin : g_rng
      assign req_oor = |req_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2];
   end else begin : g_full
      assign req_oor = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset && accept && req_write && !req_oor) begin
         mem_q[req_idx] <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         oor_q        <= 1'b0;
         idx_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q     <= WAIT;
                  cnt_q       <= CW'(LATENCY - 1);
                  wr_q        <= req_write;
                  oor_q       <= req_oor;
                  idx_q       <= req_idx;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= oor_q;
                  resp_rdata_q <= (!wr_q && !oor_q) ? mem_q[idx_q] : '0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b0;
                  req_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: latency, storage, range
// errors, backpressure, mid-operation reset and back-to-back traffic.
module tb_main_memory_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   int n_chk;
   int n_fail;

   main_memory_responder #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(16),
      .MEM_DEPTH_LOG2(8),
      .LATENCY(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction; lat reports cycles from accept edge to resp_valid.
   task automatic xact(input logic w, input logic [15:0] a,
                       input logic [15:0] d, output int lat,
                       output logic [15:0] rd, output logic er);
      int k;
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      resp_ready = 1'b0;
      k = 0;
      while (!req_ready && k < 20) begin
         tick();
         k++;
      end
      tick();
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 20) begin
         tick();
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      n_chk++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_req_ready: got %b want 1", req_ready);
      end
      n_chk++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid_busy: got %b/%b want 0/0",
                  resp_valid, busy);
      end
      n_chk++;
      if (resp_rdata !== 16'h0 || resp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_data_err: got %h/%b want 0000/0",
                  resp_rdata, resp_err);
      end
   endtask

   task automatic test_write_timing();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0010;
      req_wdata = 16'hBEEF;
      tick();
      req_valid = 1'b0;
      n_chk++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_accept: ready/busy got %b/%b want 0/1",
                  req_ready, busy);
      end
      tick();
      tick();
      tick();
      n_chk++;
      if (resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_early_valid: got %b want 0 at E+3", resp_valid);
      end
      tick();
      n_chk++;
      if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h0)
      begin
         n_fail++;
         $display("FAIL wr_resp: v/err/data got %b/%b/%h want 1/0/0000",
                  resp_valid, resp_err, resp_rdata);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      n_chk++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_handshake: v/ready got %b/%b want 0/1",
                  resp_valid, req_ready);
      end
   endtask

   task automatic test_read();
      int          lat;
      logic [15:0] rd;
      logic        er;
      xact(1'b0, 16'h0010, 16'h0, lat, rd, er);
      n_chk++;
      if (lat !== 4 || rd !== 16'hBEEF || er !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_0010: lat/data/err got %0d/%h/%b want 4/beef/0",
                  lat, rd, er);
      end
      xact(1'b1, 16'h0011, 16'h1234, lat, rd, er);
      xact(1'b0, 16'h0011, 16'h0, lat, rd, er);
      n_chk++;
      if (rd !== 16'h1234 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_0011: data/err got %h/%b want 1234/0", rd, er);
      end
      xact(1'b0, 16'h0010, 16'h0, lat, rd, er);
      n_chk++;
      if (rd !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL rd_0010_again: got %h want beef", rd);
      end
   endtask

   task automatic test_range();
      int          lat;
      logic [15:0] rd;
      logic        er;
      xact(1'b1, 16'h0000, 16'h5A5A, lat, rd, er);
      xact(1'b1, 16'h0100, 16'hDEAD, lat, rd, er);
      n_chk++;
      if (er !== 1'b1 || rd !== 16'h0 || lat !== 4) begin
         n_fail++;
         $display("FAIL oor_write: err/data/lat got %b/%h/%0d want 1/0000/4",
                  er, rd, lat);
      end
      xact(1'b0, 16'h0000, 16'h0, lat, rd, er);
      n_chk++;
      if (rd !== 16'h5A5A || er !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_no_alias: data/err got %h/%b want 5a5a/0",
                  rd, er);
      end
      xact(1'b0, 16'hFF00, 16'h0, lat, rd, er);
      n_chk++;
      if (er !== 1'b1 || rd !== 16'h0) begin
         n_fail++;
         $display("FAIL oor_read: err/data got %b/%h want 1/0000", er, rd);
      end
   endtask

   task automatic test_backpressure();
      int k;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'h0010;
      tick();
      req_addr  = 16'h0011;
      k = 0;
      while (!resp_valid && k < 20) begin
         tick();
         k++;
      end
      n_chk++;
      if (k !== 4) begin
         n_fail++;
         $display("FAIL bp_latency: got %0d cycles want 4", k);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++;
         if (resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF ||
             req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold%0d: v/data/ready got %b/%h/%b want 1/beef/0",
                     i, resp_valid, resp_rdata, req_ready);
         end
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      n_chk++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_handshake: v/ready/busy got %b/%b/%b want 0/1/0",
                  resp_valid, req_ready, busy);
      end
      tick();
      req_valid = 1'b0;
      n_chk++;
      if (req_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_held_accept: ready/busy got %b/%b want 0/1",
                  req_ready, busy);
      end
      k = 0;
      while (!resp_valid && k < 20) begin
         tick();
         k++;
      end
      n_chk++;
      if (resp_rdata !== 16'h1234 || k !== 4) begin
         n_fail++;
         $display("FAIL bp_held_data: data/lat got %h/%0d want 1234/4",
                  resp_rdata, k);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int          rises;
      int          lat;
      logic [15:0] rd;
      logic        er;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 16'hCAFE;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_chk++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: ready/busy/v got %b/%b/%b want 1/0/0",
                  req_ready, busy, resp_valid);
      end
      rises = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (resp_valid) rises++;
      end
      n_chk++;
      if (rises !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_stale: got %0d valid cycles want 0", rises);
      end
      xact(1'b0, 16'h0020, 16'h0, lat, rd, er);
      n_chk++;
      if (rd !== 16'hCAFE || er !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_kept: data/err got %h/%b want cafe/0",
                  rd, er);
      end
   endtask

   task automatic test_back_to_back();
      logic        op_w [5];
      logic [15:0] op_a [5];
      logic [15:0] op_d [5];
      logic [15:0] want [5];
      logic [15:0] got  [8];
      int          acc_cyc [5];
      int          idx;
      int          nresp;
      int          cyc;
      int          extra;
      logic        acc;
      logic        hs;
      op_w = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      op_a = '{16'h0030, 16'h0030, 16'h0031, 16'h0031, 16'h0030};
      op_d = '{16'h1111, 16'h0000, 16'h2222, 16'h0000, 16'h3333};
      want = '{16'h0000, 16'h1111, 16'h0000, 16'h2222, 16'h0000};
      idx   = 0;
      nresp = 0;
      cyc   = 0;
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_write  = op_w[0];
      req_addr   = op_a[0];
      req_wdata  = op_d[0];
      while ((idx < 5 || nresp < 5) && cyc < 200) begin
         acc = req_valid && req_ready;
         hs  = resp_valid && resp_ready;
         if (hs && nresp < 8) begin
            got[nresp] = resp_rdata;
            nresp++;
         end
         tick();
         cyc++;
         if (acc) begin
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < 5) begin
               req_write = op_w[idx];
               req_addr  = op_a[idx];
               req_wdata = op_d[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (resp_valid) extra++;
      end
      resp_ready = 1'b0;
      n_chk++;
      if (idx !== 5 || nresp !== 5 || extra !== 0) begin
         n_fail++;
         $display("FAIL b2b_counts: acc/resp/extra got %0d/%0d/%0d want 5/5/0",
                  idx, nresp, extra);
      end
      // Accept, four latency edges, handshake edge, then the re-accept.
      for (int i = 1; i < idx; i++) begin
         n_chk++;
         if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
            n_fail++;
            $display("FAIL b2b_spacing%0d: got %0d want 6",
                     i, acc_cyc[i] - acc_cyc[i-1]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (i < nresp) begin
            n_chk++;
            if (got[i] !== want[i]) begin
               n_fail++;
               $display("FAIL b2b_data%0d: got %h want %h", i, got[i], want[i]);
            end
         end
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_write_timing();
      test_read();
      test_range();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
